// File: rtl/cpu6502_pkg.sv
// Shared 6502 datapath definitions: widths, bus precharge value and the
// program-counter unit state encoding.
package cpu6502_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [BYTE_W-1:0] BUS_IDLE_DEFAULT = 8'hFF;

  typedef enum logic {
    PC_IDLE  = 1'b0,
    PC_FIXUP = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_inc16.sv
// PC source select ({ADH or PCH, PCLS}) followed by the 16-bit incrementer;
// carry7 flags a carry out of the low byte.
module pc_inc16
  import cpu6502_pkg::*;
(
  input  logic [BYTE_W-1:0] pch,
  input  logic [BYTE_W-1:0] adh_data,
  input  logic              adh_load,
  input  logic [BYTE_W-1:0] pcls_data,
  input  logic              inc,
  output logic [ADDR_W-1:0] sum,
  output logic              carry7
);

  logic [ADDR_W-1:0] sel;
  logic [BYTE_W:0]   low_sum;

  always_comb begin
    sel     = {(adh_load ? adh_data : pch), pcls_data};
    low_sum = {1'b0, pcls_data} + {{BYTE_W{1'b0}}, inc};
    sum     = sel + {{(ADDR_W-1){1'b0}}, inc};
    carry7  = low_sum[BYTE_W];
  end

endmodule

// File: rtl/pc_unit.sv
// 6502 program counter: 16-bit increment, relative branch with a one-cycle
// PCH fix-up on page crossing, and PC byte drives onto ADL/ADH/DB.
module pc_unit
  import cpu6502_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [BYTE_W-1:0] BUS_IDLE = BUS_IDLE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BYTE_W-1:0] PCLS_DATA,
  input  logic [BYTE_W-1:0] ADH_DATA,
  input  logic              ADH_LOAD,
  input  logic              UPDATE,
  input  logic              INC,
  input  logic              BRANCH,
  input  logic [BYTE_W-1:0] OFFSET,
  input  logic              PCL_ADL_EN,
  input  logic              PCH_ADH_EN,
  input  logic              PCL_DB_EN,
  input  logic              PCH_DB_EN,
  output logic [BYTE_W-1:0] PCL_OUT,
  output logic [BYTE_W-1:0] PCH_OUT,
  output logic [BYTE_W-1:0] ADL_OUT,
  output logic [BYTE_W-1:0] ADH_OUT,
  output logic [BYTE_W-1:0] DB_OUT,
  output logic              BUSY,
  output logic              PAGE_CROSS
);

  pc_state_t         state, next_state;
  logic [BYTE_W-1:0] pcl, pch;
  logic              page_cross;
  logic              dir_back;

  logic [ADDR_W-1:0] inc_sum;
  logic              inc_carry7;
  logic [BYTE_W-1:0] br_sum;
  logic              br_carry;
  logic              br_cross;

  pc_inc16 u_inc16 (
    .pch       (pch),
    .adh_data  (ADH_DATA),
    .adh_load  (ADH_LOAD),
    .pcls_data (PCLS_DATA),
    .inc       (INC),
    .sum       (inc_sum),
    .carry7    (inc_carry7)
  );

  // A forward branch crosses on carry; a backward one crosses when the
  // sign-extended add fails to carry (i.e. the low byte borrowed).
  always_comb begin
    {br_carry, br_sum} = {1'b0, PCLS_DATA} + {1'b0, OFFSET};
    br_cross           = OFFSET[BYTE_W-1] ? ~br_carry : br_carry;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= PC_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      PC_IDLE:  if (UPDATE && BRANCH && br_cross) next_state = PC_FIXUP;
      PC_FIXUP: next_state = PC_IDLE;
      default:  next_state = PC_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == PC_FIXUP);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcl        <= RESET_PC[BYTE_W-1:0];
      pch        <= RESET_PC[ADDR_W-1:BYTE_W];
      page_cross <= 1'b0;
      dir_back   <= 1'b0;
    end else begin
      case (state)
        PC_IDLE: begin
          if (UPDATE && BRANCH) begin
            pcl        <= br_sum;
            page_cross <= br_cross;
            if (br_cross) dir_back <= OFFSET[BYTE_W-1];
          end else if (UPDATE) begin
            {pch, pcl} <= inc_sum;
            page_cross <= inc_carry7;
          end else begin
            page_cross <= 1'b0;
          end
        end
        PC_FIXUP: begin
          pch        <= dir_back ? pch - 8'd1 : pch + 8'd1;
          page_cross <= 1'b0;
          dir_back   <= 1'b0;
        end
        default: page_cross <= 1'b0;
      endcase
    end
  end

  always_comb begin
    PCL_OUT    = pcl;
    PCH_OUT    = pch;
    PAGE_CROSS = page_cross;
    ADL_OUT    = PCL_ADL_EN ? pcl : BUS_IDLE;
    ADH_OUT    = PCH_ADH_EN ? pch : BUS_IDLE;
    DB_OUT     = PCL_DB_EN ? pcl : (PCH_DB_EN ? pch : BUS_IDLE);
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter unit for the 6502 datapath: holds PCL/PCH, performs the 16-bit increment and the relative-branch add, and drives PC bytes onto ADL, ADH and DB. Sits directly upstream and downstream of the PCL select register. It consumes the selected low byte (PCLS) and feeds PCL back to the select register's PCL input. Branches that cross a page take an extra fix-up cycle for PCH, as on the original part.

## Interface
Parameters:
- RESET_PC, 16'h0000, value loaded into {PCH,PCL} on reset
- BUS_IDLE, 8'hFF, value on an undriven bus output (precharged-high bus)

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RST_N  in  1  reset; synchronous, active-low
- PCLS_DATA  in  8  low byte from PCL select register
- ADH_DATA  in  8  ADH bus, alternative PCH source
- ADH_LOAD  in  1  PCH select takes ADH_DATA instead of PCH
- UPDATE  in  1  commit new PC this cycle
- INC  in  1  add 1 to selected 16-bit value on UPDATE
- BRANCH  in  1  add signed OFFSET to selected low byte on UPDATE
- OFFSET  in  8  two's-complement branch displacement
- PCL_ADL_EN / PCH_ADH_EN  in  1 each  drive PCL onto ADL / PCH onto ADH
- PCL_DB_EN / PCH_DB_EN  in  1 each  drive PCL / PCH onto DB
- PCL_OUT  out  8  registered PCL (to PCL select register)
- PCH_OUT  out  8  registered PCH
- ADL_OUT / ADH_OUT / DB_OUT  out  8 each  bus drive values
- BUSY  out  1  high during the PCH fix-up cycle
- PAGE_CROSS  out  1  registered one-cycle pulse: last update carried or borrowed across a page

## Operation
- Selected value: SEL = {ADH_LOAD ? ADH_DATA : PCH, PCLS_DATA}.
- States:
  - IDLE: handles UPDATE normally.
  - FIXUP: one cycle, then returns to IDLE.
- IDLE, UPDATE=1, BRANCH=0:
  - {PCH,PCL} <= SEL + INC, mod 2^16.
  - PAGE_CROSS <= carry out of bit 7.
- IDLE, UPDATE=1, BRANCH=1:
  - INC and ADH_LOAD are ignored, so PCH source = PCH.
  - PCL <= PCLS_DATA + OFFSET (8-bit, wrapping).
  - Forward cross: OFFSET[7]=0 and carry. Backward cross: OFFSET[7]=1 and no carry.
  - On a cross: latch direction, PAGE_CROSS <= 1, go to FIXUP.
  - Otherwise stay in IDLE with PAGE_CROSS <= 0.
- FIXUP:
  - BUSY=1.
  - PCH <= PCH + 1 (forward) or PCH − 1 (backward), wrapping mod 256.
  - UPDATE, INC, BRANCH, ADH_LOAD are ignored.
  - Return to IDLE.
- UPDATE=0 in IDLE: PC holds; PAGE_CROSS <= 0.
- Bus drives are combinational from registered PCL/PCH:
  - ADL_OUT = PCL_ADL_EN ? PCL : BUS_IDLE.
  - ADH_OUT = PCH_ADH_EN ? PCH : BUS_IDLE.
  - DB_OUT = PCL_DB_EN ? PCL : PCH_DB_EN ? PCH : BUS_IDLE. PCL wins if both enables are set.
- During FIXUP the bus drives show the pre-fix-up PCH.

## Timing
- Reset (RST_N low at an edge):
  - {PCH,PCL} = RESET_PC, state IDLE, BUSY=0, PAGE_CROSS=0, pending direction cleared.
  - Bus outputs = BUS_IDLE unless enabled.
- Reset wins over UPDATE and over FIXUP. A reset during FIXUP abandons the fix-up.
- Latency:
  - UPDATE sampled at edge N → new PCL/PCH and PAGE_CROSS visible after edge N; the same holds for BUSY on entering FIXUP.
  - Branch with page cross: PCL final after edge N, PCH final after edge N+1, BUSY high between N and N+1.
- Upstream control must not assert UPDATE while BUSY=1. If it does, the request is dropped; no queueing.
- Wrap: FFFF + INC → 0000 with PAGE_CROSS=1.
- Wrap on fix-up:
  - Forward branch from page FF → PCH 00.
  - Backward branch from page 00 → PCH FF.

## Structure
- Shared package cpu6502_pkg holds:
  - state encoding PC_IDLE/PC_FIXUP
  - BUS_IDLE default 8'hFF
  - byte/address width constants (8, 16)
- One sub-module: pc_inc16, a combinational select + 16-bit incrementer with carry-from-bit-7 output.
- The branch adder and FSM stay in pc_unit.

## Test plan
- Reset with RESET_PC=16'hFFFC → PCH_OUT=FF, PCL_OUT=FC, BUSY=0, PAGE_CROSS=0, DB_OUT=FF with enables low.
- PC=12FF, PCLS_DATA=FF, UPDATE+INC → PC=1300, PAGE_CROSS pulse 1 cycle; then PCL_ADL_EN=1 → ADL_OUT=00.
- PC=20F0, BRANCH, OFFSET=8'h20 → PCL=10 next cycle, BUSY=1 one cycle, then PCH=21.
- PC=3005, BRANCH, OFFSET=8'hF0 (−16) → PCL=F5, FIXUP, PCH=2F.
- Branch without cross: PC=4010, OFFSET=8'h05 → PC=4015, BUSY never high, PAGE_CROSS=0.
- RST_N low during FIXUP (PC=20F0 + OFFSET 20) → PC=RESET_PC, IDLE, PCH not incremented. Also ADH_LOAD=1, ADH_DATA=C0, PCLS=00, UPDATE → PC=C000.
